jtframe_spi_upload: RTL



---
 rtl/jtframe_spi_pkg.sv | 18 +
 rtl/jtframe_spi_sync.sv | 23 ++
 rtl/jtframe_spi_upload.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/jtframe_spi_pkg.sv
// Shared definitions for the IO-controller SPI link (upload and download paths).
package jtframe_spi_pkg;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t ST_IDLE   = 2'd0;
  localparam spi_state_t ST_CMD    = 2'd1;
  localparam spi_state_t ST_IGNORE = 2'd2;
  localparam spi_state_t ST_SEND   = 2'd3;

  // Command codes seen on the link; the downloader decodes the UIO_FILE_* ones.
  localparam logic [7:0] UPLOAD_CMD_DEF  = 8'h15;
  localparam logic [7:0] UIO_FILE_TX     = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
  localparam logic [7:0] UIO_FILE_INFO   = 8'h56;

endpackage

// File: rtl/jtframe_spi_sync.sv
// Two-FF synchroniser plus one history stage for an SPI pad, with edge detection.
module jtframe_spi_sync (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [2:0] stg;

  // Cleared to 0 so a pad that is already low after reset produces no fall.
  always_ff @(posedge clk) begin
    if (rst) stg <= '0;
    else     stg <= {stg[1:0], pad};
  end

  assign lvl  = stg[1];
  assign rise =  stg[1] & ~stg[2];
  assign fall = ~stg[1] &  stg[2];

endmodule

// File: rtl/jtframe_spi_upload.sv
// SPI-slave transmitter: streams core memory out on MISO after an upload command.
//
// state     | meaning
// ST_IDLE   | slave not selected, or waiting for a fresh ss fall
// ST_CMD    | shifting in the command byte on sck rises
// ST_IGNORE | command was not an upload; MISO released until ss rises
// ST_SEND   | shifting memory bytes out on sck falls, one byte prefetched
module jtframe_spi_upload
  import jtframe_spi_pkg::*;
#(
  parameter int         AW         = 16,
  parameter logic [7:0] UPLOAD_CMD = UPLOAD_CMD_DEF,
  parameter logic [7:0] FILL       = 8'hFF
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          spi_sck,
  input  logic          spi_ss,
  input  logic          spi_di,
  output logic          spi_do,
  output logic          spi_do_oe,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_ok,
  input  logic [7:0]    mem_dout,
  output logic          uploading,
  output logic          underrun
);

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic di_lvl, di_rise, di_fall;
  logic unused_sync;

  jtframe_spi_sync u_sck (.clk(clk_sys), .rst(rst), .pad(spi_sck),
                          .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall));
  jtframe_spi_sync u_ss  (.clk(clk_sys), .rst(rst), .pad(spi_ss),
                          .lvl(ss_lvl),  .rise(ss_rise),  .fall(ss_fall));
  jtframe_spi_sync u_di  (.clk(clk_sys), .rst(rst), .pad(spi_di),
                          .lvl(di_lvl),  .rise(di_rise),  .fall(di_fall));

  assign unused_sync = ^{sck_lvl, ss_rise, di_rise, di_fall};

  spi_state_t state;
  logic [7:0] cmd_sr, cmd_next, shreg, buf_data;
  logic [2:0] bit_cnt;
  logic       buf_valid, discard;
  logic       active_send, rd_done, live_done, boundary;

  assign cmd_next    = {cmd_sr[6:0], di_lvl};
  assign active_send = (state == ST_SEND) && !ss_lvl;
  assign rd_done     = mem_rd & mem_ok;
  // A read that outlived its session is drained but its data is dropped.
  assign live_done   = rd_done & ~discard & active_send;
  assign boundary    = active_send & sck_fall & (bit_cnt == 3'd0);

  assign spi_do_oe = active_send;
  assign spi_do    = active_send & shreg[7];

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_sr    <= '0;
      shreg     <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
      bit_cnt   <= '0;
      discard   <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      uploading <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (rd_done) begin
        mem_rd  <= 1'b0;
        discard <= 1'b0;
        if (live_done) begin
          mem_addr <= mem_addr + AW'(1);
          if (!boundary) begin
            buf_data  <= mem_dout;
            buf_valid <= 1'b1;
          end
        end else begin
          mem_addr <= '0;
        end
      end

      if (ss_lvl) begin
        state     <= ST_IDLE;
        uploading <= 1'b0;
        buf_valid <= 1'b0;
        bit_cnt   <= '0;
        if (mem_rd && !mem_ok) discard <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ss_fall) begin
              state    <= ST_CMD;
              bit_cnt  <= '0;
              underrun <= 1'b0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              cmd_sr  <= cmd_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (cmd_next == UPLOAD_CMD) begin
                  state     <= ST_SEND;
                  uploading <= 1'b1;
                  shreg     <= FILL;
                  // With a stale read still pending the first read waits for it.
                  if (!mem_rd) begin
                    mem_addr <= '0;
                    mem_rd   <= 1'b1;
                  end
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end
          ST_SEND: begin
            if (sck_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd0) begin
                if (live_done) begin
                  shreg <= mem_dout;
                end else if (buf_valid) begin
                  shreg     <= buf_data;
                  buf_valid <= 1'b0;
                end else begin
                  shreg    <= FILL;
                  underrun <= 1'b1;
                end
              end else begin
                shreg <= {shreg[6:0], 1'b0};
              end
            end
            if (!mem_rd && !buf_valid && !discard) mem_rd <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
